// File: rtl/icache_pkg.sv
// Shared configuration for the instruction cache: controller states and default geometry.
package icache_pkg;

    localparam int ICACHE_INDEX_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MISS = 2'd1,
        ST_DONE = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid/tag/data, combinational read, synchronous write and clear-all.
module icache_array #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_W      = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  clr_i
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    // Clear-all takes priority over a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with a single outstanding line fill to the memory controller.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic        mc_enable,
    output logic [31:0] mc_addr,
    input  logic        mc_valid,
    input  logic [31:0] mc_instr
);

    localparam int TAG_W = 30 - INDEX_BITS;

    icache_state_e state_q, state_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        mc_enable_q, mc_enable_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic        flushed_q, flushed_d;

    logic                  arr_we, arr_clr;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^if_addr[1:0];

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (if_addr[INDEX_BITS+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (arr_we),
        .wr_idx_i   (mc_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (mc_addr_q[31:INDEX_BITS+2]),
        .wr_data_i  (mc_instr),
        .clr_i      (arr_clr)
    );

    assign hit = rd_valid && (rd_tag == if_addr[31:INDEX_BITS+2]);

    always_comb begin
        state_d     = state_q;
        if_valid_d  = 1'b0;
        if_instr_d  = if_instr_q;
        mc_enable_d = mc_enable_q;
        mc_addr_d   = mc_addr_q;
        flushed_d   = flushed_q;
        arr_we      = 1'b0;
        arr_clr     = 1'b0;

        if (!rdy) begin
            if_valid_d = if_valid_q;
        end else begin
            arr_clr = flush;
            unique case (state_q)
                ST_IDLE: begin
                    if (!flush && if_enable) begin
                        if (hit) begin
                            if_valid_d = 1'b1;
                            if_instr_d = rd_data;
                        end else begin
                            mc_enable_d = 1'b1;
                            mc_addr_d   = {if_addr[31:2], 2'b00};
                            flushed_d   = 1'b0;
                            state_d     = ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    // A flush seen at any point during the fill poisons its delivery.
                    if (flush) flushed_d = 1'b1;
                    if (mc_valid) begin
                        mc_enable_d = 1'b0;
                        state_d     = ST_DONE;
                        if (!flush && !flushed_q) begin
                            arr_we     = 1'b1;
                            if_valid_d = 1'b1;
                            if_instr_d = mc_instr;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            mc_enable_q <= 1'b0;
            mc_addr_q   <= '0;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            mc_enable_q <= mc_enable_d;
            mc_addr_q   <= mc_addr_d;
            flushed_q   <= flushed_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign mc_enable = mc_enable_q;
    assign mc_addr   = mc_addr_q;

endmodule
